// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared renderer types and defaults for the frame-buffer front end
package render_pkg;

    localparam int WIDTH_DEF   = 1024;
    localparam int HEIGHT_DEF  = 768;
    localparam int ADDR_W_DEF  = 20;
    localparam int COLOR_W_DEF = 12;

    // Coordinate widths are fixed by the shading-pipeline request bus.
    localparam int X_W = 11;
    localparam int Y_W = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } colour_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/raster_pixel_scheduler_if.sv
// rtl/raster_pixel_scheduler_if.sv - request, response, write-port and status bundle of the scheduler
interface raster_pixel_scheduler_if
    import render_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF
);
    logic               start_in;
    logic [X_W-1:0]     req_x_out;
    logic [Y_W-1:0]     req_y_out;
    logic               req_valid_out;
    logic               req_ready_in;
    logic [COLOR_W-1:0] resp_color_in;
    logic               resp_valid_in;
    logic [ADDR_W-1:0]  wr_addr_out;
    logic [COLOR_W-1:0] wr_data_out;
    logic               wr_en_out;
    logic               busy_out;
    logic               frame_done_out;
    logic [7:0]         frame_count_out;
    logic               err_out;

    // Scheduler side.
    modport master (
        input  start_in, req_ready_in, resp_color_in, resp_valid_in,
        output req_x_out, req_y_out, req_valid_out,
        output wr_addr_out, wr_data_out, wr_en_out,
        output busy_out, frame_done_out, frame_count_out, err_out
    );

    // Shading pipeline / frame buffer / controller side.
    modport slave (
        output start_in, req_ready_in, resp_color_in, resp_valid_in,
        input  req_x_out, req_y_out, req_valid_out,
        input  wr_addr_out, wr_data_out, wr_en_out,
        input  busy_out, frame_done_out, frame_count_out, err_out
    );
endinterface

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - raster-order x/y counter with running linear address
module raster_counter
    import render_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HEIGHT = HEIGHT_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              clear_in,
    input  logic              advance_in,
    output logic [X_W-1:0]    x_out,
    output logic [Y_W-1:0]    y_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              last_out
);
    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    assign last_out = (x_out == X_LAST) && (y_out == Y_LAST);

    // Step through the frame; the address tracks y*WIDTH+x by counting, so no multiplier.
    always_ff @(posedge clk_in) begin
        if (!rst_in || clear_in) begin
            x_out    <= '0;
            y_out    <= '0;
            addr_out <= '0;
        end else if (advance_in) begin
            if (x_out == X_LAST) begin
                x_out <= '0;
                y_out <= (y_out == Y_LAST) ? '0 : y_out + 1'b1;
            end else begin
                x_out <= x_out + 1'b1;
            end
            addr_out <= last_out ? '0 : addr_out + 1'b1;
        end
    end
endmodule

// File: rtl/raster_pixel_scheduler.sv
// rtl/raster_pixel_scheduler.sv - sweeps a frame, issues pixel requests and writes shaded colours to the frame buffer
module raster_pixel_scheduler
    import render_pkg::*;
#(
    parameter int WIDTH           = WIDTH_DEF,
    parameter int HEIGHT          = HEIGHT_DEF,
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int COLOR_W         = COLOR_W_DEF,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    raster_pixel_scheduler_if.master bus
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    sched_state_t       state;
    logic [OUT_W-1:0]   outstanding;
    logic               wr_complete;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [COLOR_W-1:0] wr_data_q;
    logic               frame_done_q;
    logic [7:0]         frame_count_q;
    logic               err_q;

    logic               start_ok;
    logic               req_valid;
    logic               handshake;
    logic               resp_ok;
    logic               spurious;

    logic [X_W-1:0]     issue_x;
    logic [Y_W-1:0]     issue_y;
    logic [ADDR_W-1:0]  unused_issue_addr;
    logic               issue_last;
    logic [X_W-1:0]     unused_write_x;
    logic [Y_W-1:0]     unused_write_y;
    logic [ADDR_W-1:0]  write_addr;
    logic               write_last;

    assign start_ok  = (state == ST_IDLE) && bus.start_in;
    assign req_valid = (state == ST_ISSUE) && (outstanding < OUT_MAX);
    assign handshake = req_valid && bus.req_ready_in;
    // Outstanding is only non-zero in ISSUE/DRAIN, so this also gates responses by state.
    assign resp_ok   = bus.resp_valid_in && (outstanding != '0);
    assign spurious  = bus.resp_valid_in && (outstanding == '0);

    raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) u_issue_cnt (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .clear_in   (start_ok),
        .advance_in (handshake),
        .x_out      (issue_x),
        .y_out      (issue_y),
        .addr_out   (unused_issue_addr),
        .last_out   (issue_last)
    );

    raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) u_write_cnt (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .clear_in   (start_ok),
        .advance_in (resp_ok),
        .x_out      (unused_write_x),
        .y_out      (unused_write_y),
        .addr_out   (write_addr),
        .last_out   (write_last)
    );

    // Frame FSM, credit counter, registered write port and status flags.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state         <= ST_IDLE;
            outstanding   <= '0;
            wr_complete   <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            err_q         <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            wr_en_q      <= resp_ok;
            if (resp_ok) begin
                wr_addr_q <= write_addr;
                wr_data_q <= bus.resp_color_in;
                if (write_last) begin
                    wr_complete <= 1'b1;
                end
            end
            if (spurious) begin
                err_q <= 1'b1;
            end
            if (handshake && !resp_ok) begin
                outstanding <= outstanding + 1'b1;
            end else if (!handshake && resp_ok) begin
                outstanding <= outstanding - 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state       <= ST_ISSUE;
                        outstanding <= '0;
                        wr_complete <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (handshake && issue_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (outstanding == '0 && wr_complete) begin
                        state         <= ST_DONE;
                        frame_done_q  <= 1'b1;
                        frame_count_q <= frame_count_q + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_x_out       = issue_x;
    assign bus.req_y_out       = issue_y;
    assign bus.req_valid_out   = req_valid;
    assign bus.wr_addr_out     = wr_addr_q;
    assign bus.wr_data_out     = wr_data_q;
    assign bus.wr_en_out       = wr_en_q;
    assign bus.busy_out        = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign bus.frame_done_out  = frame_done_q;
    assign bus.frame_count_out = frame_count_q;
    assign bus.err_out         = err_q;
endmodule

// File: tb/tb_raster_pixel_scheduler.sv
// tb/tb_raster_pixel_scheduler.sv - directed scoreboard bench for raster_pixel_scheduler on a 4x2 frame
module tb_raster_pixel_scheduler;
    import render_pkg::*;

    localparam int W = 4;
    localparam int H = 2;
    localparam int NPIX = W * H;
    localparam int UNLIMITED = 1000000;

    typedef struct {
        logic [19:0] addr;
        logic [11:0] data;
    } exp_t;

    typedef struct {
        int      due;
        colour_t color;
    } sh_t;

    logic clk_in = 1'b0;
    logic rst_in;

    raster_pixel_scheduler_if #(.ADDR_W(20), .COLOR_W(12)) bus ();

    raster_pixel_scheduler #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(20), .COLOR_W(12), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   issue_idx = 0;
    int   wr_cnt = 0;
    int   last_wr_cyc = -10;
    int   done_cnt = 0;
    int   done_cyc = -20;
    int   resp_allow = UNLIMITED;
    bit   force_spur = 1'b0;
    exp_t exp_q[$];
    sh_t  sh_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, drive the shader model, return 1ns after the rising edge.
    task automatic cycle();
        @(negedge clk_in);
        if (bus.wr_en_out) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.wr_addr_out), 32'(e.addr));
                chk("wr_data", 32'(bus.wr_data_out), 32'(e.data));
            end
        end
        if (bus.frame_done_out) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.req_valid_out && bus.req_ready_in && rst_in) begin
            chk("req_x", 32'(bus.req_x_out), 32'(issue_idx % W));
            chk("req_y", 32'(bus.req_y_out), 32'(issue_idx / W));
            sh_q.push_back('{due: cyc + 3, color: colour_t'(12'(12'h100 + issue_idx))});
            exp_q.push_back('{addr: 20'(issue_idx), data: 12'(12'h100 + issue_idx)});
            issue_idx++;
        end
        if (force_spur) begin
            bus.resp_valid_in = 1'b1;
            bus.resp_color_in = 12'hbad;
            force_spur = 1'b0;
        end else if (sh_q.size() > 0 && sh_q[0].due <= cyc && resp_allow > 0) begin
            sh_t s;
            s = sh_q.pop_front();
            bus.resp_valid_in = 1'b1;
            bus.resp_color_in = s.color;
            resp_allow--;
        end else begin
            bus.resp_valid_in = 1'b0;
        end
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic start_frame(input string tag);
        issue_idx = 0;
        wr_cnt = 0;
        bus.start_in = 1'b1;
        cycle();
        bus.start_in = 1'b0;
        chk({tag, "_start_busy"}, 32'(bus.busy_out), 32'd1);
        chk({tag, "_start_req_valid"}, 32'(bus.req_valid_out), 32'd1);
    endtask

    task automatic run_to_done(input string tag, input int exp_count);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 200 && done_cnt == d0; i++) cycle();
        chk({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_done_after_last_wr"}, 32'(done_cyc), 32'(last_wr_cyc + 1));
        chk({tag, "_frame_count"}, 32'(bus.frame_count_out), 32'(exp_count));
        cycle();
        cycle();
        chk({tag, "_done_single"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_writes"}, 32'(wr_cnt), 32'(NPIX));
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy_out), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_x"}, 32'(bus.req_x_out), 32'd0);
        chk({tag, "_req_y"}, 32'(bus.req_y_out), 32'd0);
        chk({tag, "_req_valid"}, 32'(bus.req_valid_out), 32'd0);
        chk({tag, "_wr_en"}, 32'(bus.wr_en_out), 32'd0);
        chk({tag, "_wr_addr"}, 32'(bus.wr_addr_out), 32'd0);
        chk({tag, "_wr_data"}, 32'(bus.wr_data_out), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy_out), 32'd0);
        chk({tag, "_frame_done"}, 32'(bus.frame_done_out), 32'd0);
        chk({tag, "_frame_count"}, 32'(bus.frame_count_out), 32'd0);
        chk({tag, "_err"}, 32'(bus.err_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b0;
        bus.start_in = 1'b1;
        bus.req_ready_in = 1'b0;
        bus.resp_valid_in = 1'b0;
        bus.resp_color_in = '0;

        // Reset with start held: nothing may come out.
        repeat (3) cycle();
        chk_all_zero("reset");
        rst_in = 1'b1;
        bus.start_in = 1'b0;
        repeat (3) cycle();
        chk("reset_no_req_valid", 32'(bus.req_valid_out), 32'd0);
        chk("reset_no_handshake", 32'(issue_idx), 32'd0);

        // Full frame at full rate.
        bus.req_ready_in = 1'b1;
        start_frame("full");
        run_to_done("full", 1);
        chk("full_err", 32'(bus.err_out), 32'd0);

        // Backpressure at (2,0), plus a start pulse while busy that must be dropped.
        start_frame("bp");
        for (int i = 0; i < 20 && issue_idx < 2; i++) cycle();
        bus.req_ready_in = 1'b0;
        bus.start_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            bus.start_in = 1'b0;
            chk("bp_hold_valid", 32'(bus.req_valid_out), 32'd1);
            chk("bp_hold_x", 32'(bus.req_x_out), 32'd2);
            chk("bp_hold_y", 32'(bus.req_y_out), 32'd0);
        end
        chk("bp_no_hs_while_stalled", 32'(issue_idx), 32'd2);
        bus.req_ready_in = 1'b1;
        run_to_done("bp", 2);

        // Credit limit: no responses until four requests are outstanding.
        resp_allow = 0;
        start_frame("credit");
        repeat (8) cycle();
        chk("credit_hs_count", 32'(issue_idx), 32'd4);
        chk("credit_valid_low", 32'(bus.req_valid_out), 32'd0);
        resp_allow = 1;
        repeat (6) cycle();
        chk("credit_one_more_hs", 32'(issue_idx), 32'd5);
        chk("credit_valid_low_again", 32'(bus.req_valid_out), 32'd0);
        resp_allow = UNLIMITED;
        run_to_done("credit", 3);

        // Spurious response in IDLE.
        cycle();
        force_spur = 1'b1;
        cycle();
        cycle();
        chk("spur_no_write", 32'(bus.wr_en_out), 32'd0);
        chk("spur_err", 32'(bus.err_out), 32'd1);
        start_frame("after_spur");
        run_to_done("after_spur", 4);
        chk("after_spur_err_sticky", 32'(bus.err_out), 32'd1);

        // Reset during DRAIN.
        start_frame("mid");
        for (int i = 0; i < 40 && issue_idx < NPIX; i++) cycle();
        chk("mid_in_drain_busy", 32'(bus.busy_out), 32'd1);
        chk("mid_in_drain_valid", 32'(bus.req_valid_out), 32'd0);
        rst_in = 1'b0;
        cycle();
        sh_q.delete();
        exp_q.delete();
        cycle();
        chk_all_zero("mid_reset");
        rst_in = 1'b1;
        cycle();
        start_frame("post_reset");
        run_to_done("post_reset", 1);
        chk("post_reset_err", 32'(bus.err_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/raster_pixel_scheduler.md
# raster_pixel_scheduler

Upstream stage of the three-dimensional renderer's frame buffer. On a start pulse it sweeps every pixel of the frame in raster order and issues coordinates to the shading pipeline over a valid/ready handshake. It collects the in-order 12-bit colour responses and drives them as write address, data and enable onto the write port (port B) of the RGB frame buffer. The display side reads that buffer independently.

## Interface
Parameters:
- WIDTH, 1024: pixels per line.
- HEIGHT, 768: lines per frame.
- ADDR_W, 20: frame-buffer address width; must satisfy 2^ADDR_W ≥ WIDTH·HEIGHT.
- COLOR_W, 12: colour width, packed 4:4:4 RGB.
- MAX_OUTSTANDING, 4: maximum requests issued but not yet answered; must be at least 1.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: one clock; reset is synchronous and active-low.
- start_in, input, 1: one-cycle pulse that begins a frame; ignored unless IDLE.
- req_x_out, output, 11: requested pixel x.
- req_y_out, output, 10: requested pixel y.
- req_valid_out, output, 1: request valid.
- req_ready_in, input, 1: shading pipeline accepts the request.
- resp_color_in, input, COLOR_W: shaded colour.
- resp_valid_in, input, 1: response valid; always accepted, no backpressure.
- wr_addr_out, output, ADDR_W: frame-buffer write address.
- wr_data_out, output, COLOR_W: frame-buffer write data.
- wr_en_out, output, 1: frame-buffer write enable.
- busy_out, output, 1: high in ISSUE and DRAIN.
- frame_done_out, output, 1: one-cycle pulse when the frame completes.
- frame_count_out, output, 8: completed frames; wraps 255→0.
- err_out, output, 1: sticky; set by a response arriving with nothing outstanding.

## Operation
- States are IDLE, ISSUE, DRAIN and DONE.
- **IDLE**
  - start_in clears the issue and write raster counters and the outstanding count, then moves to ISSUE.
- **ISSUE**
  - req_valid_out = (outstanding < MAX_OUTSTANDING).
  - A handshake occurs when req_valid_out and req_ready_in are both high. It advances the issue counter and increments outstanding.
  - Issue counter advance: x increments; at x = WIDTH-1, x wraps to 0 and y increments.
  - The handshake at (WIDTH-1, HEIGHT-1) moves the state to DRAIN.
  - While req_valid_out is high and no handshake occurs, req_x_out and req_y_out hold stable.
- **Responses (ISSUE and DRAIN)**
  - Each resp_valid_in with outstanding > 0 performs one write: address = write_y·WIDTH + write_x, data = resp_color_in.
  - The write then advances the write raster counter and decrements outstanding.
  - A handshake and a response in the same cycle leave outstanding unchanged.
- **DRAIN**
  - Holds req_valid_out low.
  - When outstanding reaches 0 and the final write has been issued, moves to DONE.
- **DONE** (one cycle)
  - Pulses frame_done_out, increments frame_count_out, then returns to IDLE.
- **Spurious responses**
  - resp_valid_in with outstanding = 0, in any state, sets err_out and produces no write.
  - err_out is cleared only by reset.
- **Write address arithmetic**
  - The write address is kept as a running counter that increments by 1 per write; no multiplier is used.
  - It equals y·WIDTH + x by construction.
  - For WIDTH = 1024 it equals {y, x[9:0]}.

## Timing
- **Reset:** state IDLE; every output is 0, including req_x_out, req_y_out, wr_addr_out, wr_data_out, frame_count_out and err_out.
- **Reset mid-frame:** aborts the frame immediately with no further writes. In-flight responses arriving afterwards count as spurious.
- **Start latency:** start_in at cycle t gives busy_out = 1 and req_valid_out = 1 at cycle t+1.
- **Write latency:** resp_valid_in at cycle t gives wr_en_out, wr_addr_out and wr_data_out registered at t+1. wr_en_out stays high for exactly one cycle per response.
- **Frame completion:** the final write appears at cycle t. DRAIN→DONE then puts frame_done_out at t+1, and frame_count_out updates in the same cycle.
- **Throughput:** one pixel per cycle when req_ready_in is held high and the responses keep outstanding below MAX_OUTSTANDING.
- **Minimum frame time:** WIDTH·HEIGHT cycles plus the pipeline latency plus 2.
- **Start while busy:** a start_in in ISSUE, DRAIN or DONE is dropped; it is neither queued nor restarted.

## Structure
- **Shared package render_pkg:**
  - WIDTH and HEIGHT defaults;
  - the colour_t typedef (COLOR_W bits, 4:4:4 fields);
  - the scheduler state enum;
  - the address width constant.
- **Sub-module raster_counter:**
  - Contains the x/y counter with end-of-line and end-of-frame wrap, an advance input, a clear input, and a last_out flag.
  - It also keeps the running linear address.
  - Instantiate it twice: once for the issue side and once for the write side.
- The outstanding counter and the FSM live at the top level.

## Test plan
Use WIDTH=4, HEIGHT=2, MAX_OUTSTANDING=4.
1. **Reset:** hold rst_in low for 3 cycles → every output 0. start_in while rst_in is low → no requests.
2. **Full frame:** start; req_ready_in always 1; shader returns colour = 12'h100+index after 3 cycles → 8 writes to addresses 0..7 with data 12'h100..12'h107. frame_done_out pulses once, 1 cycle after the last write. frame_count_out = 1.
3. **Backpressure:** req_ready_in low for 5 cycles at pixel (2,0) → req_x_out=2, req_y_out=0 held stable. No duplicate or skipped coordinates after release.
4. **Credit limit:** no responses → exactly 4 handshakes ((0,0)..(3,0)), then req_valid_out low. One response → exactly one more handshake, at (0,1).
5. **Spurious response:** resp_valid_in in IDLE → wr_en_out stays 0 and err_out = 1 until reset. A frame run afterwards still completes correctly.
6. **Mid-frame reset:** reset during DRAIN → outputs cleared. The next start issues (0,0) first, writes begin at address 0, and frame_count_out = 1 after completion.
